// File: rtl/transmit_ordered_set_if.sv
// -----------------------------------------------------------------------------
// transmit_ordered_set_if
// Bundles the GMII transmit controls, the encoder handshake and the
// ordered-set request outputs of the PCS transmit ordered-set machine.
//   TXD              [7:0] GMII transmit octet (read only while carrier-extending)
//   TX_EN                  GMII transmit enable
//   TX_ER                  GMII transmit error / carrier-extend request
//   TX_OSET_indicate       encoder finished the previous ordered set
//   tx_o_set         [7:0] requested ordered set (/I/ /S/ /D/ /T/ /R/ /V/)
//   transmitting           high while a packet is on the wire
//   tx_even                code-group parity, high = even
// master : the GMII/encoder side that drives the controls
// slave  : the ordered-set machine
// -----------------------------------------------------------------------------
interface transmit_ordered_set_if;
  logic [7:0] TXD;
  logic       TX_EN;
  logic       TX_ER;
  logic       TX_OSET_indicate;
  logic [7:0] tx_o_set;
  logic       transmitting;
  logic       tx_even;

  modport master (
    output TXD, TX_EN, TX_ER, TX_OSET_indicate,
    input  tx_o_set, transmitting, tx_even
  );

  modport slave (
    input  TXD, TX_EN, TX_ER, TX_OSET_indicate,
    output tx_o_set, transmitting, tx_even
  );
endinterface

// File: rtl/transmit_ordered_set.sv
// -----------------------------------------------------------------------------
// transmit_ordered_set
// 1000BASE-X PCS transmit ordered-set state machine. Turns GMII TX_EN/TX_ER
// (and TXD during carrier extension) into one ordered-set request per code
// group for the encoder. The state advances only on edges where the encoder
// reports TX_OSET_indicate; tx_even toggles on each such advance.
// Ports:
//   CLK    rising-edge clock
//   RESET  synchronous active-high reset (forces XMIT_DATA, tx_even=1)
//   bus    transmit_ordered_set_if.slave (see interface file for signals)
// Build option:
//   CARRIER_EXT_EN  when defined, builds END_OF_PACKET_EXT, CARRIER_EXTEND and
//                   EXTEND_BY_1; otherwise an end with TX_ER=1 is treated as a
//                   normal end of packet and TXD is ignored.
// -----------------------------------------------------------------------------
module transmit_ordered_set (
  input  logic                        CLK,
  input  logic                        RESET,
  transmit_ordered_set_if.slave       bus
);

  localparam logic [7:0] OS_I = 8'h49;
  localparam logic [7:0] OS_S = 8'h53;
  localparam logic [7:0] OS_D = 8'h44;
  localparam logic [7:0] OS_T = 8'h54;
  localparam logic [7:0] OS_R = 8'h52;
  localparam logic [7:0] OS_V = 8'h56;

  typedef enum logic [3:0] {
    XMIT_DATA           = 4'd0,
    START_OF_PACKET     = 4'd1,
    START_ERROR         = 4'd2,
    TX_DATA             = 4'd3,
    TX_DATA_ERROR       = 4'd4,
    END_OF_PACKET_NOEXT = 4'd5,
    EPD2_NOEXT          = 4'd6,
    EPD3                = 4'd7,
    END_OF_PACKET_EXT   = 4'd8,
    CARRIER_EXTEND      = 4'd9,
    EXTEND_BY_1         = 4'd10
  } state_t;

  state_t     state_reg, state_next;
  logic       tx_even_reg;
  logic       state_legal;
  logic [7:0] o_set;
  logic       xmit;

  // Where a packet in progress goes next, given the sampled GMII controls.
  function automatic state_t pkt_next(input logic en, input logic er);
    if (en) begin
      pkt_next = er ? TX_DATA_ERROR : TX_DATA;
    end else begin
`ifdef CARRIER_EXT_EN
      pkt_next = er ? END_OF_PACKET_EXT : END_OF_PACKET_NOEXT;
`else
      pkt_next = END_OF_PACKET_NOEXT;
`endif
    end
  endfunction

`ifndef CARRIER_EXT_EN
  // TXD only matters while carrier-extending.
  logic unused_txd;
  assign unused_txd = ^bus.TXD;
`endif

  // An unreachable encoding must recover without waiting for the encoder,
  // so the register also loads when the current state is illegal.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= XMIT_DATA;
      tx_even_reg <= 1'b1;
    end else if (!state_legal) begin
      state_reg   <= XMIT_DATA;
    end else if (bus.TX_OSET_indicate) begin
      state_reg   <= state_next;
      tx_even_reg <= ~tx_even_reg;
    end
  end

  always_comb begin
    state_next  = state_reg;
    state_legal = 1'b1;
    o_set       = OS_I;
    xmit        = 1'b0;
    unique case (state_reg)
      XMIT_DATA: begin
        o_set = OS_I;
        if (bus.TX_EN)
          state_next = bus.TX_ER ? START_ERROR : START_OF_PACKET;
      end
      START_OF_PACKET: begin
        o_set      = OS_S;
        xmit       = 1'b1;
        state_next = pkt_next(bus.TX_EN, bus.TX_ER);
      end
      START_ERROR: begin
        o_set      = OS_S;
        xmit       = 1'b1;
        state_next = TX_DATA_ERROR;
      end
      TX_DATA: begin
        o_set      = OS_D;
        xmit       = 1'b1;
        state_next = pkt_next(bus.TX_EN, bus.TX_ER);
      end
      TX_DATA_ERROR: begin
        o_set      = OS_V;
        xmit       = 1'b1;
        state_next = pkt_next(bus.TX_EN, bus.TX_ER);
      end
      END_OF_PACKET_NOEXT: begin
        o_set      = OS_T;
        state_next = EPD2_NOEXT;
      end
      EPD2_NOEXT: begin
        // A second /R/ is needed only to realign the idle onto an even slot.
        o_set      = OS_R;
        state_next = tx_even_reg ? EPD3 : XMIT_DATA;
      end
      EPD3: begin
        o_set      = OS_R;
        state_next = XMIT_DATA;
      end
`ifdef CARRIER_EXT_EN
      END_OF_PACKET_EXT: begin
        o_set      = OS_T;
        state_next = bus.TX_ER ? CARRIER_EXTEND : EXTEND_BY_1;
      end
      CARRIER_EXTEND: begin
        o_set = (bus.TXD == 8'h0F) ? OS_R : OS_V;
        if (!bus.TX_EN && !bus.TX_ER)
          state_next = EXTEND_BY_1;
        else if (bus.TX_EN)
          state_next = bus.TX_ER ? START_ERROR : START_OF_PACKET;
      end
      EXTEND_BY_1: begin
        o_set      = OS_R;
        state_next = EPD2_NOEXT;
      end
`endif
      default: begin
        state_legal = 1'b0;
        state_next  = XMIT_DATA;
      end
    endcase
  end

  assign bus.tx_o_set     = o_set;
  assign bus.transmitting = xmit;
  assign bus.tx_even      = tx_even_reg;

endmodule

// File: tb/tb_transmit_ordered_set.sv
module tb_transmit_ordered_set;

  logic clk;
  logic rst;
  transmit_ordered_set_if bus ();

  transmit_ordered_set dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] oset;
    logic       tr;
    logic       ev;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model, states named by their ordered-set role.
  typedef enum {M_IDLE, M_SOP, M_SERR, M_DATA, M_DERR, M_EOP, M_EPD2,
                M_EPD3, M_EOPX, M_CEXT, M_EXT1} m_t;
  m_t   m_state;
  logic m_even;

  function automatic m_t rule_p(input logic en, input logic er);
    if (en && !er) return M_DATA;
    if (en && er)  return M_DERR;
`ifdef CARRIER_EXT_EN
    if (er)        return M_EOPX;
`endif
    return M_EOP;
  endfunction

  function automatic exp_t m_outputs(input logic [7:0] txd);
    exp_t e;
    e.ev = m_even;
    e.tr = (m_state inside {M_SOP, M_SERR, M_DATA, M_DERR});
    case (m_state)
      M_IDLE:                e.oset = 8'h49;
      M_SOP, M_SERR:         e.oset = 8'h53;
      M_DATA:                e.oset = 8'h44;
      M_DERR:                e.oset = 8'h56;
      M_EOP, M_EOPX:         e.oset = 8'h54;
      M_CEXT:                e.oset = (txd == 8'h0F) ? 8'h52 : 8'h56;
      default:               e.oset = 8'h52;
    endcase
    return e;
  endfunction

  function automatic void m_step(input logic en, input logic er, input logic ind,
                                 input logic r);
    m_t n;
    if (r) begin
      m_state = M_IDLE;
      m_even  = 1'b1;
    end else if (ind) begin
      n = m_state;
      case (m_state)
        M_IDLE: if (en) n = er ? M_SERR : M_SOP;
        M_SOP, M_DATA, M_DERR: n = rule_p(en, er);
        M_SERR: n = M_DERR;
        M_EOP:  n = M_EPD2;
        M_EPD2: n = m_even ? M_EPD3 : M_IDLE;
        M_EPD3: n = M_IDLE;
        M_EOPX: n = er ? M_CEXT : M_EXT1;
        M_CEXT: begin
          if (!en && !er)     n = M_EXT1;
          else if (en && !er) n = M_SOP;
          else if (en && er)  n = M_SERR;
        end
        M_EXT1: n = M_EPD2;
        default: n = M_IDLE;
      endcase
      m_state = n;
      m_even  = ~m_even;
    end
  endfunction

  // One clock: drive controls, push the expected outputs, clock, compare.
  task automatic step(input string tag, input logic en, input logic er,
                      input logic ind, input logic r, input logic [7:0] txd);
    exp_t e;
    rst                  = r;
    bus.TX_EN            = en;
    bus.TX_ER            = er;
    bus.TX_OSET_indicate = ind;
    bus.TXD              = txd;
    m_step(en, er, ind, r);
    exp_q.push_back(m_outputs(txd));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    assert (bus.tx_o_set === e.oset) else begin
      bad++;
      $error("FAIL %s tx_o_set got=%h exp=%h", tag, bus.tx_o_set, e.oset);
    end
    total++;
    assert (bus.transmitting === e.tr) else begin
      bad++;
      $error("FAIL %s transmitting got=%b exp=%b", tag, bus.transmitting, e.tr);
    end
    total++;
    assert (bus.tx_even === e.ev) else begin
      bad++;
      $error("FAIL %s tx_even got=%b exp=%b", tag, bus.tx_even, e.ev);
    end
    $display("%-8s en=%b er=%b ind=%b rst=%b txd=%h -> oset=%h tr=%b ev=%b",
             tag, en, er, ind, r, txd, bus.tx_o_set, bus.transmitting, bus.tx_even);
  endtask

  initial begin
    m_state = M_IDLE;
    m_even  = 1'b1;
    rst = 1'b1;
    bus.TX_EN = 1'b0; bus.TX_ER = 1'b0; bus.TX_OSET_indicate = 1'b1; bus.TXD = 8'h00;
    #1;

    // reset then idle
    step("reset", 0, 0, 1, 1, 8'h00);
    for (int i = 0; i < 4; i++) step("idle", 0, 0, 1, 0, 8'h00);

    // odd packet
    for (int i = 0; i < 4; i++) step("odd_en", 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step("odd_end", 0, 0, 1, 0, 8'h00);

    // even packet
    for (int i = 0; i < 5; i++) step("even_en", 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step("even_end", 0, 0, 1, 0, 8'h00);

    // start error, then mid-packet error
    step("start_er", 1, 1, 1, 0, 8'h00);
    for (int i = 0; i < 2; i++) step("data", 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 2; i++) step("mid_er", 1, 1, 1, 0, 8'h00);
    for (int i = 0; i < 2; i++) step("data", 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step("err_end", 0, 0, 1, 0, 8'h00);

    // stall mid-packet with TX_EN toggling
    for (int i = 0; i < 3; i++) step("pre_stl", 1, 0, 1, 0, 8'h00);
    step("stall", 0, 1, 0, 0, 8'h00);
    step("stall", 1, 1, 0, 0, 8'h00);
    step("stall", 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++) step("post_stl", 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) step("stl_end", 0, 0, 1, 0, 8'h00);

    // end with carrier extension, TXD=0F then TXD=00
    for (int i = 0; i < 3; i++) step("cx_pkt", 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 2; i++) step("cx_r", 0, 1, 1, 0, 8'h0F);
    for (int i = 0; i < 6; i++) step("cx_end", 0, 0, 1, 0, 8'h0F);
    for (int i = 0; i < 4; i++) step("cx_pkt", 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step("cx_v", 0, 1, 1, 0, 8'h00);
    for (int i = 0; i < 6; i++) step("cx_end", 0, 0, 1, 0, 8'h00);
    // extension straight back into a new packet
    for (int i = 0; i < 2; i++) step("cx_pkt", 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 2; i++) step("cx_r", 0, 1, 1, 0, 8'h0F);
    for (int i = 0; i < 3; i++) step("cx_back", 1, 0, 1, 0, 8'h0F);
    for (int i = 0; i < 5; i++) step("cx_end", 0, 0, 1, 0, 8'h00);

    // reset mid-packet, including reset while the encoder is stalled
    for (int i = 0; i < 3; i++) step("rst_pkt", 1, 0, 1, 0, 8'h00);
    step("rst_mid", 1, 0, 1, 1, 8'h00);
    for (int i = 0; i < 2; i++) step("rst_idl", 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step("rst_pkt", 1, 0, 1, 0, 8'h00);
    step("rst_stl", 1, 0, 0, 1, 8'h00);
    for (int i = 0; i < 3; i++) step("rst_idl", 0, 0, 1, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
